seq_calc_unit: RTL

- Clocked, parametrised successor to the combinational 16-bit calculator datapath (add/sub/mul/div/mod, 4-bit opcode, 2-bit error).
- Operand width is generalised to WIDTH, and MUL/DIV/MOD become iterative multi-cycle units behind a start/busy/done handshake.
- Adds an accumulator register that can be used as operand A, which allows chained calculations.
- Sits between the operand/opcode source (testbench or front-panel logic) and the result display path.

---
 rtl/calc_pkg.sv | 22 ++
 rtl/iter_muldiv.sv | 63 ++++++
 rtl/seq_calc_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared opcodes, FSM state encoding and error-bit positions for the
// sequential calculator and its iterative multiply/divide unit.
package calc_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_CLR = 4'd5;

  localparam int ERR_OVF  = 0;
  localparam int ERR_DIV0 = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/iter_muldiv.sv
// Shared shift-add multiplier / restoring divider datapath, one bit per step.
// The upper half of pr holds the partial product/remainder, the lower half the multiplier/quotient.
module iter_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] nxt,
  output logic               last
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] pr;
  logic [WIDTH-1:0]   opnd;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_sub;

  // nxt is the value pr takes after this step; on the last step the top
  // commits it directly so the result is ready on DONE entry.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    nxt     = pr;
    mul_sum = {1'b0, pr[2*WIDTH-1:WIDTH]} + (pr[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    rem_sh  = {pr[2*WIDTH-1:WIDTH], pr[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, opnd};
    if (is_div) begin
      // Borrow out of the trial subtraction means the divisor did not fit.
      if (rem_sub[WIDTH])
        nxt = {rem_sh[WIDTH-1:0], pr[WIDTH-2:0], 1'b0};
      else
        nxt = {rem_sub[WIDTH-1:0], pr[WIDTH-2:0], 1'b1};
    end else begin
      nxt = {mul_sum, pr[WIDTH-1:1]};
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pr   <= '0;
      opnd <= '0;
      cnt  <= '0;
    end else if (load) begin
      pr   <= is_div ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
      opnd <= is_div ? b : a;
      cnt  <= '0;
    end else if (step) begin
      pr   <= nxt;
      cnt  <= cnt + CNT_W'(1);
    end
  end

  assign last = step && (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/seq_calc_unit.sv
// Clocked calculator: single-cycle ADD/SUB/CLR/NOP, iterative MUL/DIV/MOD,
// with an accumulator that can stand in for operand A to chain operations.
module seq_calc_unit
  import calc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               use_acc,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic [1:0]         error,
  output logic [WIDTH-1:0]   acc
);

  state_t             state, state_next;
  logic [3:0]         op_q;
  logic               accept;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb_x;
  logic [WIDTH:0]     sum;
  logic               ovf;
  logic               it_load;
  logic               it_div;
  logic               it_last;
  logic [2*WIDTH-1:0] it_nxt;
  logic               commit;
  logic               acc_we;
  logic [2*WIDTH-1:0] commit_result;
  logic [1:0]         commit_error;

  assign busy   = (state == ST_MUL) || (state == ST_DIV);
  assign done   = (state == ST_DONE);
  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

  // In DONE, acc already holds the value committed on DONE entry, so a
  // chained start with use_acc sees the fresh result.
  assign opa   = use_acc ? acc : a;
  assign opb_x = (op == OP_SUB) ? ~b : b;
  assign sum   = {1'b0, opa} + {1'b0, opb_x} + {{WIDTH{1'b0}}, (op == OP_SUB)};
  // Carry into the MSB recovered from the MSB sum bit; overflow is it XOR carry out.
  assign ovf   = (sum[WIDTH-1] ^ opa[WIDTH-1] ^ opb_x[WIDTH-1]) ^ sum[WIDTH];

  assign it_div = (state == ST_DIV) || (it_load && (op != OP_MUL));

  iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (it_load),
    .step   (busy),
    .is_div (it_div),
    .a      (opa),
    .b      (b),
    .nxt    (it_nxt),
    .last   (it_last)
  );

  always_comb begin
    state_next    = state;
    it_load       = 1'b0;
    commit        = 1'b0;
    acc_we        = 1'b0;
    commit_result = '0;
    commit_error  = 2'b00;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          case (op)
            OP_ADD, OP_SUB: begin
              state_next             = ST_DONE;
              commit                 = 1'b1;
              acc_we                 = 1'b1;
              commit_result          = {{WIDTH{sum[WIDTH]}}, sum[WIDTH-1:0]};
              commit_error[ERR_OVF]  = ovf;
            end
            OP_MUL: begin
              state_next = ST_MUL;
              it_load    = 1'b1;
            end
            OP_DIV, OP_MOD: begin
              if (b == '0) begin
                state_next             = ST_DONE;
                commit                 = 1'b1;
                acc_we                 = 1'b1;
                commit_error[ERR_DIV0] = 1'b1;
              end else begin
                state_next = ST_DIV;
                it_load    = 1'b1;
              end
            end
            OP_CLR: begin
              state_next = ST_DONE;
              commit     = 1'b1;
              acc_we     = 1'b1;
            end
            default: begin
              state_next = ST_DONE;
              commit     = 1'b1;
            end
          endcase
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (it_last) begin
          state_next    = ST_DONE;
          commit        = 1'b1;
          acc_we        = 1'b1;
          commit_result = it_nxt;
        end
      end
      ST_DIV: begin
        if (it_last) begin
          state_next    = ST_DONE;
          commit        = 1'b1;
          acc_we        = 1'b1;
          commit_result = (op_q == OP_MOD) ? {{WIDTH{1'b0}}, it_nxt[2*WIDTH-1:WIDTH]}
                                           : {{WIDTH{1'b0}}, it_nxt[WIDTH-1:0]};
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_IDLE;
      op_q   <= OP_ADD;
      result <= '0;
      error  <= 2'b00;
      acc    <= '0;
    end else begin
      state <= state_next;
      if (accept) op_q <= op;
      if (commit) begin
        result <= commit_result;
        error  <= commit_error;
      end
      if (acc_we) acc <= commit_result[WIDTH-1:0];
    end
  end

endmodule
